// File: rtl/tdm_demux_if.sv
// Sample-stream and lane-output bundle for tdm_demux.
// master = TDM source / lane consumer side, slave = the demux itself.
interface tdm_demux_if #(
    parameter int WIDTH = 1,
    parameter int CH    = 4
);
    localparam int SELW = $clog2(CH);

    // In_valid qualifies In and Sync for one cycle; there is no backpressure.
    // Out_valid and Err are one-cycle strobes and are never asserted together.
    logic [WIDTH-1:0]    In;
    logic                In_valid;
    logic                Sync;
    logic [CH*WIDTH-1:0] Out;
    logic                Out_valid;
    logic [SELW-1:0]     Sel;
    logic                Err;
    logic                state;     // 0 = HUNT, 1 = RUN

    modport master (
        output In, In_valid, Sync,
        input  Out, Out_valid, Sel, Err, state
    );

    modport slave (
        input  In, In_valid, Sync,
        output Out, Out_valid, Sel, Err, state
    );
endinterface

// File: rtl/tdm_demux.sv
// TDM receive demux: collects one frame of CH slot samples, then publishes all lanes at once.
// Define TDM_STRICT_SYNC_EN to treat a missing Sync at slot 0 as an alignment error.
module tdm_demux #(
    parameter int WIDTH = 1,
    parameter int CH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    tdm_demux_if.slave bus
);
    localparam int SELW = $clog2(CH);
    localparam logic [SELW-1:0] LAST = SELW'(CH - 1);
    localparam logic [SELW-1:0] ONE  = SELW'(1);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

`ifdef TDM_STRICT_SYNC_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic [0:0]          state;
    logic [SELW-1:0]     sel;
    logic [CH*WIDTH-1:0] shadow;
    logic [CH*WIDTH-1:0] out;
    logic                out_valid;
    logic                err;

    logic [CH*WIDTH-1:0] lane_write;
    logic [CH*WIDTH-1:0] realign;

    // lane_write bypasses the current sample so the last lane reaches Out without a readback.
    always_comb begin
        lane_write = shadow;
        lane_write[int'(sel)*WIDTH +: WIDTH] = bus.In;
        realign = '0;
        realign[WIDTH-1:0] = bus.In;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HUNT;
            sel       <= '0;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            if (bus.In_valid) begin
                case (state)
                    HUNT: begin
                        if (bus.Sync) begin
                            shadow <= realign;
                            sel    <= ONE;
                            state  <= RUN;
                        end
                    end
                    default: begin
                        if (bus.Sync && sel != '0) begin
                            // Early Sync: drop the partial frame and restart at slot 0.
                            err    <= 1'b1;
                            shadow <= realign;
                            sel    <= ONE;
                        end else if (STRICT && !bus.Sync && sel == '0) begin
                            err    <= 1'b1;
                            shadow <= '0;
                            sel    <= '0;
                            state  <= HUNT;
                        end else begin
                            shadow <= lane_write;
                            sel    <= sel + ONE;
                            if (sel == LAST) begin
                                out       <= lane_write;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.Out       = out;
    assign bus.Out_valid = out_valid;
    assign bus.Sel       = sel;
    assign bus.Err       = err;
    assign bus.state     = state;
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CH=4, WIDTH=1) with a queue-based output scoreboard.
module tb_tdm_demux;
    localparam int WIDTH = 1;
    localparam int CH    = 4;
    localparam int W     = CH * WIDTH;

    logic clk;
    logic reset_n;

    tdm_demux_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

    tdm_demux #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;
    int err_exp = 0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic send(input logic d, input logic s);
        bus.In       = d;
        bus.Sync     = s;
        bus.In_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.In_valid = 1'b0;
        bus.Sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.Out_valid && bus.Err) begin
                tests++;
                fails++;
                $display("[TB] FAIL strobe_overlap: Out_valid=1 Err=1 expected not both");
            end
            if (bus.Out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_out_valid: got Out=%0h expected no frame", bus.Out);
                end else begin
                    chk("frame_out", 32'(bus.Out), 32'(exp_q.pop_front()));
                end
            end
            if (bus.Err) begin
                tests++;
                if (err_exp == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_err: got Err=1 expected 0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    initial begin
        bus.In       = '0;
        bus.In_valid = 1'b0;
        bus.Sync     = 1'b0;
        reset_n      = 1'b0;
        idle(2);
        chk("reset_out",       32'(bus.Out),       32'h0);
        chk("reset_out_valid", 32'(bus.Out_valid), 32'h0);
        chk("reset_sel",       32'(bus.Sel),       32'h0);
        chk("reset_err",       32'(bus.Err),       32'h0);
        chk("reset_state",     32'(bus.state),     32'h0);
        reset_n = 1'b1;
        idle(1);

        // basic frame 1,0,1,1 -> lanes 3..0 = 1101
        exp_q.push_back(4'b1101);
        send(1'b1, 1'b1);
        chk("sel_after_slot0", 32'(bus.Sel), 32'h1);
        chk("state_run", 32'(bus.state), 32'h1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("sel_wrap", 32'(bus.Sel), 32'h0);
        chk("out_at_strobe", 32'(bus.Out), 32'hd);
        idle(3);
        chk("out_hold", 32'(bus.Out), 32'hd);
        chk("out_valid_one_cycle", 32'(bus.Out_valid), 32'h0);

        // no Sync after reset -> ignored in HUNT
        apply_reset();
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        chk("hunt_sel", 32'(bus.Sel), 32'h0);
        chk("hunt_out", 32'(bus.Out), 32'h0);
        chk("hunt_state", 32'(bus.state), 32'h0);
        exp_q.push_back(4'b0010);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        idle(2);

        // early Sync aborts the partial frame
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        err_exp++;
        send(1'b0, 1'b1);
        chk("sel_after_realign", 32'(bus.Sel), 32'h1);
        exp_q.push_back(4'b1110);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        idle(2);

        // back-to-back frames with idle gaps mid-frame
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b1100);
        send(1'b1, 1'b1);
        idle(2);
        send(1'b1, 1'b0);
        chk("gap_sel", 32'(bus.Sel), 32'h2);
        idle(1);
        chk("gap_sel_hold", 32'(bus.Sel), 32'h2);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        idle(3);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        idle(2);
        chk("b2b_out", 32'(bus.Out), 32'hc);

        // asynchronous reset mid-frame
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out",   32'(bus.Out),   32'h0);
        chk("async_sel",   32'(bus.Sel),   32'h0);
        chk("async_state", 32'(bus.state), 32'h0);
        chk("async_err",   32'(bus.Err),   32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        exp_q.push_back(4'b1001);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        idle(2);

        // second frame without Sync on slot 0
        exp_q.push_back(4'b1111);
        send(1'b1, 1'b1);
        send(1'b1, 1'b1 ^ 1'b1);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
`ifdef TDM_STRICT_SYNC_EN
        err_exp++;
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        idle(2);
        chk("strict_state", 32'(bus.state), 32'h0);
        chk("strict_out_kept", 32'(bus.Out), 32'hf);
`else
        exp_q.push_back(4'b1110);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        idle(2);
        chk("free_run_state", 32'(bus.state), 32'h1);
        chk("free_run_out", 32'(bus.Out), 32'he);
`endif
        idle(3);
        chk("frames_pending", 32'(exp_q.size()), 32'h0);
        chk("errs_pending", 32'(err_exp), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive side of the channel-select mux path: takes a time-division-multiplexed sample stream (one channel per slot, slot 0 flagged by Sync) and routes each sample back to its channel lane.
- Assembles one full frame of CH samples in a shadow buffer, then publishes all lanes at once with a one-cycle Out_valid strobe.
- Tracks frame alignment with a HUNT/RUN state machine and flags misaligned Sync.

Parameters:
- WIDTH, 1, bits per channel sample.
- CH, 4, channels per frame; power of 2, at least 2.
- SELW, $clog2(CH), slot index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- In  input  WIDTH  sample for the current slot.
- In_valid  input  1  In is a valid sample this cycle.
- Sync  input  1  qualified by In_valid; marks the sample as slot 0.
- Out  output  CH*WIDTH  channel lanes; lane i = Out[i*WIDTH +: WIDTH].
- Out_valid  output  1  one-cycle strobe when Out is updated.
- Sel  output  SELW  slot index the next valid sample will be written to.
- Err  output  1  one-cycle strobe on an alignment error.

Behaviour:
- Interface decision: one clock (clk); reset_n is asynchronous, active-low.
- Reset: Out=0, Out_valid=0, Sel=0, Err=0, shadow=0, state=HUNT. Reset asserted mid-frame discards the partial frame.
- An accepted sample is a cycle with In_valid=1. Cycles with In_valid=0 change nothing; Out_valid and Err drop to 0.
- HUNT state:
  - Samples without Sync are ignored.
  - In_valid and Sync: write shadow[0]=In, Sel<=1, go to RUN.
- RUN state, accepted sample:
  - Sync=1 with Sel!=0: Err=1 next cycle; partial frame discarded; sample written to shadow[0]; Sel<=1.
  - Otherwise: write shadow[Sel]=In; Sel<=Sel+1, wrapping CH-1 to 0.
  - Sync=0 at Sel=0 is legal (free-running) unless STRICT_SYNC_EN is defined.
- Frame completion: on the cycle after the sample accepted at Sel=CH-1:
  - Out holds all CH lanes, including the just-written last lane (bypassed, not read back from shadow).
  - Out_valid=1 for exactly that one cycle.
  - Out then holds until the next completion.
- Latency: 1 cycle from the last-slot sample to Out/Out_valid.
- Back-to-back frames: slot 0 of the next frame may arrive on the same cycle as Out_valid, with no bubble required.
- Out_valid and Err are both registered; they are never asserted together by the same sample.
- Sel is registered and always valid; the driving side may use it as the slot select.

Optional Feature:
- Macro: TDM_STRICT_SYNC_EN.
- Defined: in RUN, an accepted sample at Sel=0 with Sync=0 sets Err=1 next cycle, discards the sample, sets Sel=0 and returns to HUNT.
- Not defined: Sync is required only to leave HUNT or to realign; a missing Sync at slot 0 is accepted silently.

Test Plan:
- Reset, then 4 valid samples with CH=4, WIDTH=1: In=1 (Sync=1), 0, 1, 1 -> one cycle after the 4th sample, Out=4'b1101 and Out_valid=1 for one cycle; Sel back to 0.
- Samples 1, 1 with no Sync after reset -> ignored; Sel stays 0 and Out stays 0. Then the frame 0 (Sync), 1, 0, 0 -> Out=4'b0010.
- Frame 1 (Sync), 0, then a sample with Sync=1 and In=0 -> Err pulse; continue 1, 1, 1 -> Out=4'b1110; partial data from the aborted frame is absent.
- Two back-to-back frames with In_valid gaps mid-frame: 1,1,0,0 then 0,0,1,1 -> Out_valid pulses twice with Out=4'b0011 then 4'b1100; gaps do not advance Sel.
- reset_n asserted after 2 samples of a frame -> all outputs 0 immediately (asynchronous), with no clock edge needed; the next full Sync frame decodes correctly.
- TDM_STRICT_SYNC_EN defined: send a second frame with no Sync on slot 0 -> Err pulse, state returns to HUNT, no Out_valid. Without the macro, the same stimulus produces Out_valid and no Err.
